// File: rtl/bcp_pkg.sv
// Shared types and encodings for the clause-side BCP responder.
// Result, free-literal-count and variable-value codes match the lit1 cell chain.
package bcp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_DECIDE,
        ST_IMPLY,
        ST_CONFL,
        ST_DONE
    } bcp_state_t;

    localparam logic [1:0] RES_UNDEF = 2'd0;
    localparam logic [1:0] RES_SAT   = 2'd1;
    localparam logic [1:0] RES_UNIT  = 2'd2;
    localparam logic [1:0] RES_CONFL = 2'd3;

    // Chain-end free-literal count; 2 never occurs on a healthy chain.
    localparam logic [1:0] FLC_NONE    = 2'd0;
    localparam logic [1:0] FLC_ONE     = 2'd1;
    localparam logic [1:0] FLC_ILLEGAL = 2'd2;
    localparam logic [1:0] FLC_MANY    = 2'd3;

    localparam logic [1:0] VAR_FREE     = 2'd0;
    localparam logic [1:0] VAR_FALSE    = 2'd1;
    localparam logic [1:0] VAR_TRUE     = 2'd2;
    localparam logic [1:0] VAR_CONFLICT = 2'd3;

endpackage

// File: rtl/bcp_down_counter.sv
// Loadable down counter with a zero flag; holds at zero rather than wrapping.
module bcp_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en && (count != '0))
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/clause_bcp_ctrl.sv
// Clause responder at the tail of a lit1 chain: settles, classifies the clause,
// drives implication/conflict back into the chain and handshakes with the BCP controller.
module clause_bcp_ctrl
    import bcp_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int ACK_TIMEOUT   = 8,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [1:0]       freelitcnt_i,
    input  logic             clausesat_i,
    input  logic             imp_ack_i,
    output logic             imp_drv_o,
    output logic             conflict_c_drv_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [1:0]       result_o,
    output logic             err_o,
    output logic [CNT_W-1:0] imp_cnt_o
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int ACK_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [ACK_W-1:0] ACK_LOAD = ACK_W'(ACK_TIMEOUT - 1);

    bcp_state_t       state, state_next;
    logic [1:0]       result_next;
    logic             err_next;
    logic             cnt_inc;
    logic [CNT_W-1:0] imp_cnt_next;
    logic             settle_zero, ack_zero;
    logic             imp_drv_d, conflict_d, busy_d, done_d;

    bcp_down_counter #(.W(SET_W)) u_settle_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     ((state == ST_IDLE) && start_i),
        .en       (state == ST_SETTLE),
        .load_val (SET_LOAD),
        .zero     (settle_zero)
    );

    bcp_down_counter #(.W(ACK_W)) u_ack_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (state == ST_DECIDE),
        .en       (state == ST_IMPLY),
        .load_val (ACK_LOAD),
        .zero     (ack_zero)
    );

    // Outputs are registered alongside the state so they are glitch-free Moore outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            imp_drv_o        <= 1'b0;
            conflict_c_drv_o <= 1'b0;
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
            result_o         <= RES_UNDEF;
            err_o            <= 1'b0;
            imp_cnt_o        <= '0;
        end else begin
            state            <= state_next;
            imp_drv_o        <= imp_drv_d;
            conflict_c_drv_o <= conflict_d;
            busy_o           <= busy_d;
            done_o           <= done_d;
            result_o         <= result_next;
            err_o            <= err_next;
            imp_cnt_o        <= imp_cnt_next;
        end
    end

    always_comb begin
        state_next  = state;
        result_next = result_o;
        err_next    = err_o;
        cnt_inc     = 1'b0;
        if (abort_i) begin
            state_next  = ST_IDLE;
            result_next = RES_UNDEF;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        state_next  = ST_SETTLE;
                        result_next = RES_UNDEF;
                    end
                end
                ST_SETTLE: begin
                    if (settle_zero)
                        state_next = ST_DECIDE;
                end
                ST_DECIDE: begin
                    // A satisfied clause outranks whatever the free count says.
                    if (clausesat_i) begin
                        state_next  = ST_DONE;
                        result_next = RES_SAT;
                    end else begin
                        case (freelitcnt_i)
                            FLC_NONE: begin
                                state_next  = ST_CONFL;
                                result_next = RES_CONFL;
                            end
                            FLC_ONE:  state_next = ST_IMPLY;
                            FLC_MANY: begin
                                state_next  = ST_DONE;
                                result_next = RES_UNDEF;
                            end
                            default: begin
                                state_next  = ST_DONE;
                                result_next = RES_UNDEF;
                                err_next    = 1'b1;
                            end
                        endcase
                    end
                end
                ST_IMPLY: begin
                    // Ack is checked before the timeout so a last-cycle ack still counts.
                    if (imp_ack_i) begin
                        state_next  = ST_DONE;
                        result_next = RES_UNIT;
                        cnt_inc     = 1'b1;
                    end else if (ack_zero) begin
                        state_next  = ST_DONE;
                        result_next = RES_UNDEF;
                        err_next    = 1'b1;
                    end
                end
                ST_CONFL: state_next = ST_DONE;
                ST_DONE:  state_next = ST_IDLE;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        imp_drv_d    = (state_next == ST_IMPLY);
        conflict_d   = (state_next == ST_CONFL);
        busy_d       = (state_next != ST_IDLE);
        done_d       = (state_next == ST_DONE);
        imp_cnt_next = imp_cnt_o;
        if (cnt_inc && (imp_cnt_o != '1))
            imp_cnt_next = imp_cnt_o + 1'b1;
    end

endmodule

// File: tb/tb_clause_bcp_ctrl.sv
// Directed self-checking bench for clause_bcp_ctrl with SETTLE_CYCLES=2, ACK_TIMEOUT=8.
module tb_clause_bcp_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [1:0]  freelitcnt_i = 2'd3;
    logic        clausesat_i = 1'b0;
    logic        imp_ack_i = 1'b0;
    logic        imp_drv_o, conflict_c_drv_o, busy_o, done_o, err_o;
    logic [1:0]  result_o;
    logic [15:0] imp_cnt_o;

    int checks = 0;
    int failures = 0;

    clause_bcp_ctrl #(.SETTLE_CYCLES(2), .ACK_TIMEOUT(8), .CNT_W(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .start_i          (start_i),
        .abort_i          (abort_i),
        .freelitcnt_i     (freelitcnt_i),
        .clausesat_i      (clausesat_i),
        .imp_ack_i        (imp_ack_i),
        .imp_drv_o        (imp_drv_o),
        .conflict_c_drv_o (conflict_c_drv_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .result_o         (result_o),
        .err_o            (err_o),
        .imp_cnt_o        (imp_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives start so it is sampled at edge T; returns #1 after edge T (cycle T+1).
    task automatic start_eval(input logic [1:0] fl, input logic sat);
        freelitcnt_i = fl;
        clausesat_i  = sat;
        start_i      = 1'b1;
        step();
        start_i      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++; if (imp_drv_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_imp_drv: got %b expected 0", imp_drv_o); end
        checks++; if (conflict_c_drv_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_conflict: got %b expected 0", conflict_c_drv_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_o); end
        checks++; if (done_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", done_o); end
        checks++; if (result_o !== 2'd0) begin failures++; $display("[TB] FAIL reset_result: got %0d expected 0", result_o); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_err: got %b expected 0", err_o); end
        checks++; if (imp_cnt_o !== 16'd0) begin failures++; $display("[TB] FAIL reset_imp_cnt: got %0d expected 0", imp_cnt_o); end
        step();
    endtask

    task automatic test_sat();
        start_eval(2'd3, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            checks++; if (done_o !== (k == 4)) begin failures++; $display("[TB] FAIL sat_done k=%0d: got %b expected %b", k, done_o, (k == 4)); end
            checks++; if ((imp_drv_o | conflict_c_drv_o) !== 1'b0) begin failures++; $display("[TB] FAIL sat_drives k=%0d: got %b expected 0", k, imp_drv_o | conflict_c_drv_o); end
            checks++; if (busy_o !== (k <= 4)) begin failures++; $display("[TB] FAIL sat_busy k=%0d: got %b expected %b", k, busy_o, (k <= 4)); end
            if (k >= 4) begin
                checks++; if (result_o !== 2'd1) begin failures++; $display("[TB] FAIL sat_result k=%0d: got %0d expected 1", k, result_o); end
            end
            step();
        end
        clausesat_i = 1'b0;
    endtask

    task automatic test_unit();
        start_eval(2'd1, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            imp_ack_i = (k == 6);
            checks++; if (imp_drv_o !== (k >= 4 && k <= 6)) begin failures++; $display("[TB] FAIL unit_imp_drv k=%0d: got %b expected %b", k, imp_drv_o, (k >= 4 && k <= 6)); end
            checks++; if (done_o !== (k == 7)) begin failures++; $display("[TB] FAIL unit_done k=%0d: got %b expected %b", k, done_o, (k == 7)); end
            if (k == 7) begin
                checks++; if (result_o !== 2'd2) begin failures++; $display("[TB] FAIL unit_result: got %0d expected 2", result_o); end
                checks++; if (imp_cnt_o !== 16'd1) begin failures++; $display("[TB] FAIL unit_imp_cnt: got %0d expected 1", imp_cnt_o); end
            end
            step();
        end
        imp_ack_i = 1'b0;
    endtask

    task automatic test_conflict();
        start_eval(2'd0, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            checks++; if (conflict_c_drv_o !== (k == 4)) begin failures++; $display("[TB] FAIL confl_drv k=%0d: got %b expected %b", k, conflict_c_drv_o, (k == 4)); end
            checks++; if (done_o !== (k == 5)) begin failures++; $display("[TB] FAIL confl_done k=%0d: got %b expected %b", k, done_o, (k == 5)); end
            checks++; if (imp_drv_o !== 1'b0) begin failures++; $display("[TB] FAIL confl_imp_drv k=%0d: got %b expected 0", k, imp_drv_o); end
            if (k == 5) begin
                checks++; if (result_o !== 2'd3) begin failures++; $display("[TB] FAIL confl_result: got %0d expected 3", result_o); end
            end
            step();
        end
    endtask

    task automatic test_undef();
        start_eval(2'd3, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            checks++; if (done_o !== (k == 4)) begin failures++; $display("[TB] FAIL undef_done k=%0d: got %b expected %b", k, done_o, (k == 4)); end
            if (k == 4) begin
                checks++; if (result_o !== 2'd0) begin failures++; $display("[TB] FAIL undef_result: got %0d expected 0", result_o); end
                checks++; if (err_o !== 1'b0) begin failures++; $display("[TB] FAIL undef_err: got %b expected 0", err_o); end
            end
            step();
        end
    endtask

    task automatic test_abort();
        start_eval(2'd1, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            abort_i = (k == 5);
            if (k == 5) begin
                checks++; if (imp_drv_o !== 1'b1) begin failures++; $display("[TB] FAIL abort_pre_imp_drv: got %b expected 1", imp_drv_o); end
            end
            if (k >= 6) begin
                checks++; if (imp_drv_o !== 1'b0) begin failures++; $display("[TB] FAIL abort_imp_drv k=%0d: got %b expected 0", k, imp_drv_o); end
                checks++; if (busy_o !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy k=%0d: got %b expected 0", k, busy_o); end
                checks++; if (done_o !== 1'b0) begin failures++; $display("[TB] FAIL abort_done k=%0d: got %b expected 0", k, done_o); end
            end
            if (k == 6) begin
                checks++; if (result_o !== 2'd0) begin failures++; $display("[TB] FAIL abort_result: got %0d expected 0", result_o); end
                checks++; if (imp_cnt_o !== 16'd1) begin failures++; $display("[TB] FAIL abort_imp_cnt: got %0d expected 1", imp_cnt_o); end
                checks++; if (err_o !== 1'b0) begin failures++; $display("[TB] FAIL abort_err: got %b expected 0", err_o); end
            end
            step();
        end
        abort_i = 1'b0;
    endtask

    task automatic test_timeout();
        int drv_cycles = 0;
        start_eval(2'd1, 1'b0);
        for (int k = 1; k <= 13; k++) begin
            if (imp_drv_o === 1'b1) drv_cycles++;
            checks++; if (imp_drv_o !== (k >= 4 && k <= 11)) begin failures++; $display("[TB] FAIL tmo_imp_drv k=%0d: got %b expected %b", k, imp_drv_o, (k >= 4 && k <= 11)); end
            checks++; if (done_o !== (k == 12)) begin failures++; $display("[TB] FAIL tmo_done k=%0d: got %b expected %b", k, done_o, (k == 12)); end
            checks++; if (err_o !== (k >= 12)) begin failures++; $display("[TB] FAIL tmo_err k=%0d: got %b expected %b", k, err_o, (k >= 12)); end
            if (k == 12) begin
                checks++; if (result_o !== 2'd0) begin failures++; $display("[TB] FAIL tmo_result: got %0d expected 0", result_o); end
                checks++; if (imp_cnt_o !== 16'd1) begin failures++; $display("[TB] FAIL tmo_imp_cnt: got %0d expected 1", imp_cnt_o); end
            end
            step();
        end
        checks++; if (drv_cycles != 8) begin failures++; $display("[TB] FAIL tmo_drv_len: got %0d expected 8", drv_cycles); end
    endtask

    task automatic test_illegal();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (err_o !== 1'b0 || imp_cnt_o !== 16'd0) begin failures++; $display("[TB] FAIL rereset: got err=%b cnt=%0d expected err=0 cnt=0", err_o, imp_cnt_o); end
        start_eval(2'd2, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            checks++; if (done_o !== (k == 4)) begin failures++; $display("[TB] FAIL illegal_done k=%0d: got %b expected %b", k, done_o, (k == 4)); end
            checks++; if (err_o !== (k >= 4)) begin failures++; $display("[TB] FAIL illegal_err k=%0d: got %b expected %b", k, err_o, (k >= 4)); end
            if (k == 4) begin
                checks++; if (result_o !== 2'd0) begin failures++; $display("[TB] FAIL illegal_result: got %0d expected 0", result_o); end
            end
            step();
        end
        start_eval(2'd3, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            checks++; if (err_o !== 1'b1) begin failures++; $display("[TB] FAIL err_sticky k=%0d: got %b expected 1", k, err_o); end
            step();
        end
    endtask

    // start held high: ignored in SETTLE/DECIDE/DONE, re-accepted once back in IDLE.
    task automatic test_back_to_back();
        freelitcnt_i = 2'd3;
        clausesat_i  = 1'b1;
        start_i      = 1'b1;
        step();
        for (int k = 1; k <= 10; k++) begin
            if (k == 8) start_i = 1'b0;
            checks++; if (done_o !== (k == 4 || k == 9)) begin failures++; $display("[TB] FAIL b2b_done k=%0d: got %b expected %b", k, done_o, (k == 4 || k == 9)); end
            checks++; if (busy_o !== (k != 5 && k != 10)) begin failures++; $display("[TB] FAIL b2b_busy k=%0d: got %b expected %b", k, busy_o, (k != 5 && k != 10)); end
            step();
        end
        start_i     = 1'b0;
        clausesat_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sat();
        test_unit();
        test_conflict();
        test_undef();
        test_abort();
        test_timeout();
        test_illegal();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clause_bcp_ctrl.md
Name: clause_bcp_ctrl

Overview:
- Clause-side responder at the tail of a lit1 cell chain.
- After each variable assignment, waits for the chain to settle, then samples the chain-end free-literal count and clause-satisfied flag.
- Classifies the clause as SAT, UNIT, CONFLICT or UNDEF, and drives the implication or conflict line back into the chain.
- Reports completion to the global BCP controller via a start/done handshake.

Parameters:
- SETTLE_CYCLES, 2, cycles waited after start before sampling the chain; legal range >= 1.
- ACK_TIMEOUT, 8, maximum IMPLY cycles waiting for imp_ack_i; legal range >= 1.
- CNT_W, 16, width of the saturating implication counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- start_i  in  1  request evaluation; accepted only in IDLE.
- abort_i  in  1  backtrack; cancels evaluation.
- freelitcnt_i  in  2  chain-end free-literal count: 0 = none, 1 = one, 3 = two or more, 2 = illegal.
- clausesat_i  in  1  OR of lit clausesat outputs.
- imp_ack_i  in  1  variable side has accepted the implication.
- imp_drv_o  out  1  drives imp_drv_i of all lit cells.
- conflict_c_drv_o  out  1  drives conflict_c_drv_i of all lit cells.
- busy_o  out  1  high whenever state is not IDLE.
- done_o  out  1  single-cycle completion pulse.
- result_o  out  2  0 = UNDEF, 1 = SAT, 2 = UNIT, 3 = CONFLICT; held until next accepted start or abort.
- err_o  out  1  sticky: illegal count or ack timeout seen; cleared only by rst.
- imp_cnt_o  out  CNT_W  implications acknowledged; saturates at all-ones.

Behaviour:
- All outputs are registered and Moore-decoded from state.
- Reset: state IDLE; all outputs 0, including result_o, err_o and imp_cnt_o.
- rst has priority over abort_i; abort_i has priority over everything else.
- States: IDLE, SETTLE, DECIDE, IMPLY, CONFL, DONE.
- IDLE:
  - start_i=1 -> SETTLE; counter loaded with SETTLE_CYCLES-1; result_o cleared to 0.
  - start_i in any other state is ignored, including the DONE cycle.
- SETTLE: counter decrements each cycle; at 0 -> DECIDE. SETTLE lasts exactly SETTLE_CYCLES cycles.
- DECIDE (one cycle): samples the inputs and resolves in this priority order:
  - clausesat_i=1 -> result SAT, go DONE.
  - freelitcnt_i=0 -> CONFL.
  - freelitcnt_i=1 -> IMPLY.
  - freelitcnt_i=3 -> result UNDEF, go DONE.
  - freelitcnt_i=2 -> err_o set, result UNDEF, go DONE.
- IMPLY:
  - imp_drv_o=1 for every cycle in IMPLY; timeout counter runs.
  - imp_ack_i high at an edge -> DONE, result UNIT, imp_cnt_o+1 (saturating).
  - No ack within ACK_TIMEOUT cycles -> err_o set, result UNDEF, go DONE.
  - If ack arrives on the final timeout cycle, ack wins.
- CONFL: conflict_c_drv_o=1 for exactly one cycle; result CONFLICT; go DONE.
- DONE: done_o=1 for one cycle -> IDLE.
- Latency (start sampled at edge T, S = SETTLE_CYCLES):
  - DECIDE occupies cycle T+S+1.
  - SAT/UNDEF: done_o at T+S+2.
  - CONFLICT: conflict_c_drv_o at T+S+2, done_o at T+S+3.
  - UNIT: imp_drv_o from T+S+2; if ack is sampled at edge A, imp_drv_o=0 and done_o=1 at A+1.
- abort_i (any state):
  - Next cycle: IDLE; imp_drv_o=0, conflict_c_drv_o=0, busy_o=0.
  - No done_o pulse; result_o = 0; imp_cnt_o and err_o unchanged.
- Inputs are sampled only in DECIDE and IMPLY; changes during SETTLE are don't-care.

Decomposition:
- Shared package bcp_pkg:
  - result codes: RES_UNDEF, RES_SAT, RES_UNIT, RES_CONFL.
  - freelitcnt codes: FLC_NONE=0, FLC_ONE=1, FLC_MANY=3.
  - var_value codes: free=0, false=1, true=2, conflict=3.
  - state enum.
- Sub-module: bcp_down_counter, reused for both the settle and timeout counters (load, enable, zero flag).

Test Plan (SETTLE_CYCLES=2, ACK_TIMEOUT=8):
- Reset: rst=1 for 2 cycles -> all outputs 0, busy_o=0.
- SAT: clausesat_i=1, freelitcnt_i=3, start at T -> done_o only at T+4; result_o=1; imp_drv_o and conflict_c_drv_o never high.
- UNIT: freelitcnt_i=1, start at T, imp_ack_i high at edge T+6 -> imp_drv_o=1 during T+4..T+6; done_o at T+7; result_o=2; imp_cnt_o=1.
- CONFLICT: freelitcnt_i=0, start at T -> conflict_c_drv_o=1 only at T+4; done_o at T+5; result_o=3.
- UNDEF/illegal:
  - freelitcnt_i=3 -> done_o at T+4, result_o=0, err_o=0.
  - Then freelitcnt_i=2 -> result_o=0, err_o=1 and stays 1.
- Abort/timeout:
  - abort_i during IMPLY -> imp_drv_o=0 next cycle, no done_o, result_o=0.
  - No ack -> imp_drv_o high for exactly 8 cycles, then done_o, result_o=0, err_o=1, imp_cnt_o unchanged.
